// File: rtl/id_operand_pipe_pkg.sv
// id_operand_pipe_pkg: shared NOP encodings, zero word and FSM state type for the ID/EX operand pipe.
package id_operand_pipe_pkg;
   localparam logic [7:0]  EXE_NOP_OP  = 8'b0000_0000;
   localparam logic [2:0]  EXE_RES_NOP = 3'b000;
   localparam logic [31:0] ZeroWord    = 32'h0000_0000;
   typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;
endpackage

// File: rtl/id_operand_pipe_bypass.sv
// operand_bypass: resolves one operand through prioritised forwarding sources and flags load-use hazards.
module operand_bypass import id_operand_pipe_pkg::*; #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int NUM_FWD = 2
) (
   input  logic                       rd,
   input  logic [RADDR_W-1:0]         addr,
   input  logic [DATA_W-1:0]          data,
   input  logic [DATA_W-1:0]          imm,
   input  logic [NUM_FWD-1:0]         fwd_wreg,
   input  logic [NUM_FWD*RADDR_W-1:0] fwd_wd,
   input  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata,
   input  logic [NUM_FWD-1:0]         fwd_pending,
   output logic [DATA_W-1:0]          opnd,
   output logic                       hazard
);
   // Scan oldest to youngest so the youngest matching source overwrites the rest.
   always_comb begin
      opnd   = data;
      hazard = 1'b0;
      for (int i = NUM_FWD - 1; i >= 0; i--)
         if (fwd_wreg[i] && fwd_wd[i*RADDR_W +: RADDR_W] == addr) begin
            opnd   = fwd_wdata[i*DATA_W +: DATA_W];
            hazard = fwd_pending[i];
         end
      if (!rd || addr == '0) begin
         opnd   = rd ? DATA_W'(ZeroWord) : imm;
         hazard = 1'b0;
      end
   end
endmodule

// File: rtl/id_operand_pipe.sv
// id_operand_pipe: decode-stage operand resolution with forwarding, load-use interlock and ID/EX register.
module id_operand_pipe import id_operand_pipe_pkg::*; #(
   parameter int DATA_W   = 32,
   parameter int RADDR_W  = 5,
   parameter int NUM_FWD  = 2,
   parameter int ALUOP_W  = 8,
   parameter int ALUSEL_W = 3,
   parameter int CNT_W    = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       id_valid_i,
   output logic                       id_ready_o,
   input  logic                       reg1_read_i,
   input  logic                       reg2_read_i,
   input  logic [RADDR_W-1:0]         reg1_addr_i,
   input  logic [RADDR_W-1:0]         reg2_addr_i,
   input  logic [DATA_W-1:0]          reg1_data_i,
   input  logic [DATA_W-1:0]          reg2_data_i,
   input  logic [DATA_W-1:0]          imm_i,
   input  logic [ALUOP_W-1:0]         aluop_i,
   input  logic [ALUSEL_W-1:0]        alusel_i,
   input  logic [RADDR_W-1:0]         wd_i,
   input  logic                       wreg_i,
   input  logic [NUM_FWD-1:0]         fwd_wreg_i,
   input  logic [NUM_FWD*RADDR_W-1:0] fwd_wd_i,
   input  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata_i,
   input  logic [NUM_FWD-1:0]         fwd_pending_i,
   input  logic                       flush_i,
   input  logic                       ex_ready_i,
   output logic                       ex_valid_o,
   output logic [ALUOP_W-1:0]         ex_aluop_o,
   output logic [ALUSEL_W-1:0]        ex_alusel_o,
   output logic [DATA_W-1:0]          ex_reg1_o,
   output logic [DATA_W-1:0]          ex_reg2_o,
   output logic [RADDR_W-1:0]         ex_wd_o,
   output logic                       ex_wreg_o,
   output logic                       hazard_o,
   output logic [CNT_W-1:0]           stall_cnt_o
);
   logic [DATA_W-1:0] op1, op2;
   logic              hz1, hz2;
   state_t            state, state_nxt;
   operand_bypass #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .NUM_FWD(NUM_FWD)) u_op1 (
      .rd(reg1_read_i), .addr(reg1_addr_i), .data(reg1_data_i), .imm(imm_i),
      .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i),
      .fwd_pending(fwd_pending_i), .opnd(op1), .hazard(hz1));
   operand_bypass #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .NUM_FWD(NUM_FWD)) u_op2 (
      .rd(reg2_read_i), .addr(reg2_addr_i), .data(reg2_data_i), .imm(imm_i),
      .fwd_wreg(fwd_wreg_i), .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i),
      .fwd_pending(fwd_pending_i), .opnd(op2), .hazard(hz2));
   assign hazard_o   = id_valid_i & (hz1 | hz2);
   assign id_ready_o = ~flush_i & ~hazard_o & (~ex_valid_o | ex_ready_i);
   assign state_nxt  = (state == RUN) ? ((hazard_o && !flush_i) ? STALL : RUN)
                                      : ((!hazard_o || flush_i) ? RUN : STALL);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state       <= RUN;
         stall_cnt_o <= '0;
         ex_valid_o  <= 1'b0;
         ex_aluop_o  <= '0;
         ex_alusel_o <= '0;
         ex_reg1_o   <= '0;
         ex_reg2_o   <= '0;
         ex_wd_o     <= '0;
         ex_wreg_o   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt == STALL && stall_cnt_o != '1)
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
         // Flush and empty cycles share the NOP bubble; a blocked slot holds.
         if (flush_i || !ex_valid_o || ex_ready_i) begin
            if (!flush_i && id_valid_i && id_ready_o) begin
               ex_valid_o  <= 1'b1;
               ex_aluop_o  <= aluop_i;
               ex_alusel_o <= alusel_i;
               ex_reg1_o   <= op1;
               ex_reg2_o   <= op2;
               ex_wd_o     <= wd_i;
               ex_wreg_o   <= wreg_i;
            end else begin
               ex_valid_o  <= 1'b0;
               ex_aluop_o  <= ALUOP_W'(EXE_NOP_OP);
               ex_alusel_o <= ALUSEL_W'(EXE_RES_NOP);
               ex_wreg_o   <= 1'b0;
            end
         end
      end
endmodule

// File: tb/tb_id_operand_pipe.sv
// tb_id_operand_pipe: directed and random checks of id_operand_pipe against a behavioural model.
module tb_id_operand_pipe;
   localparam int DW = 32, AW = 5, NF = 2, OW = 8, SW = 3, CW = 16;
   logic clk = 1'b0, rst;
   logic id_valid_i, id_ready_o, reg1_read_i, reg2_read_i;
   logic [AW-1:0] reg1_addr_i, reg2_addr_i, wd_i, ex_wd_o;
   logic [DW-1:0] reg1_data_i, reg2_data_i, imm_i, ex_reg1_o, ex_reg2_o;
   logic [OW-1:0] aluop_i, ex_aluop_o;
   logic [SW-1:0] alusel_i, ex_alusel_o;
   logic wreg_i, flush_i, ex_ready_i, ex_valid_o, ex_wreg_o, hazard_o;
   logic [NF-1:0] fwd_wreg_i, fwd_pending_i;
   logic [NF*AW-1:0] fwd_wd_i;
   logic [NF*DW-1:0] fwd_wdata_i;
   logic [CW-1:0] stall_cnt_o;
   int vectors = 0, miscompares = 0;
   logic m_valid, m_wreg;
   logic [OW-1:0] m_aluop;
   logic [SW-1:0] m_alusel;
   logic [DW-1:0] m_r1, m_r2;
   logic [AW-1:0] m_wd;
   int m_cnt;

   id_operand_pipe dut (
      .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
      .reg1_read_i(reg1_read_i), .reg2_read_i(reg2_read_i),
      .reg1_addr_i(reg1_addr_i), .reg2_addr_i(reg2_addr_i),
      .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .imm_i(imm_i),
      .aluop_i(aluop_i), .alusel_i(alusel_i), .wd_i(wd_i), .wreg_i(wreg_i),
      .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
      .fwd_pending_i(fwd_pending_i), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
      .ex_valid_o(ex_valid_o), .ex_aluop_o(ex_aluop_o), .ex_alusel_o(ex_alusel_o),
      .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o), .ex_wd_o(ex_wd_o),
      .ex_wreg_o(ex_wreg_o), .hazard_o(hazard_o), .stall_cnt_o(stall_cnt_o));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s got=%0h want=%0h at %0t", n, a, e, $time);
      end
   endtask

   // Returns {hazard, value}: youngest matching source wins, r0 and immediates never forward.
   function automatic logic [DW:0] resolve(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (!rd) return {1'b0, imm_i};
      if (a == 0) return '0;
      for (int i = 0; i < NF; i++)
         if (fwd_wreg_i[i] && fwd_wd_i[i*AW +: AW] == a)
            return {fwd_pending_i[i], fwd_wdata_i[i*DW +: DW]};
      return {1'b0, d};
   endfunction

   task automatic model_reset();
      m_valid = 0; m_wreg = 0; m_aluop = 0; m_alusel = 0;
      m_r1 = 0; m_r2 = 0; m_wd = 0; m_cnt = 0;
   endtask

   task automatic idle();
      id_valid_i = 0; reg1_read_i = 0; reg2_read_i = 0; reg1_addr_i = 0; reg2_addr_i = 0;
      reg1_data_i = 0; reg2_data_i = 0; imm_i = 0; aluop_i = 0; alusel_i = 0; wd_i = 0;
      wreg_i = 0; fwd_wreg_i = 0; fwd_wd_i = 0; fwd_wdata_i = 0; fwd_pending_i = 0;
      flush_i = 0; ex_ready_i = 1;
   endtask

   // One clock: check combinational outputs, advance the model across the edge, check registers.
   task automatic cycle();
      logic [DW:0] o1, o2;
      logic hz, rdy;
      #1;
      o1 = resolve(reg1_read_i, reg1_addr_i, reg1_data_i);
      o2 = resolve(reg2_read_i, reg2_addr_i, reg2_data_i);
      hz = id_valid_i && (o1[DW] || o2[DW]);
      rdy = !flush_i && !hz && (!m_valid || ex_ready_i);
      chk("hazard_o", hazard_o, hz);
      chk("id_ready_o", id_ready_o, rdy);
      @(posedge clk);
      if (hz && !flush_i && m_cnt < (1 << CW) - 1) m_cnt++;
      if (flush_i || !(m_valid && !ex_ready_i)) begin
         if (!flush_i && id_valid_i && rdy) begin
            m_valid = 1; m_wreg = wreg_i; m_aluop = aluop_i; m_alusel = alusel_i;
            m_r1 = o1[DW-1:0]; m_r2 = o2[DW-1:0]; m_wd = wd_i;
         end else begin
            m_valid = 0; m_wreg = 0; m_aluop = 0; m_alusel = 0;
         end
      end
      #1;
      chk("ex_valid_o", ex_valid_o, m_valid);
      chk("ex_wreg_o", ex_wreg_o, m_wreg);
      chk("ex_aluop_o", ex_aluop_o, m_aluop);
      chk("ex_alusel_o", ex_alusel_o, m_alusel);
      chk("stall_cnt_o", stall_cnt_o, m_cnt);
      if (m_valid) begin
         chk("ex_reg1_o", ex_reg1_o, m_r1);
         chk("ex_reg2_o", ex_reg2_o, m_r2);
         chk("ex_wd_o", ex_wd_o, m_wd);
      end
   endtask

   initial begin
      idle();
      rst = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1;
      chk("rst_valid", ex_valid_o, 0);
      chk("rst_cnt", stall_cnt_o, 0);
      chk("rst_aluop", ex_aluop_o, 0);
      // OR r3, imm
      id_valid_i = 1; reg1_read_i = 1; reg1_addr_i = 3; reg1_data_i = 32'hF0;
      imm_i = 32'hFFFF; aluop_i = 8'h25; alusel_i = 3'b001; wd_i = 4; wreg_i = 1;
      cycle();
      chk("t1_valid", ex_valid_o, 1);
      chk("t1_reg1", ex_reg1_o, 32'hF0);
      chk("t1_reg2", ex_reg2_o, 32'hFFFF);
      // forwarding priority and r0 suppression
      reg1_addr_i = 5; fwd_wreg_i = 2'b11; fwd_wd_i = {5'd5, 5'd5}; fwd_wdata_i = {32'h22, 32'h11};
      cycle();
      chk("fwd_young", ex_reg1_o, 32'h11);
      fwd_wreg_i = 2'b10;
      cycle();
      chk("fwd_old", ex_reg1_o, 32'h22);
      reg1_addr_i = 0; fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd0}; fwd_wdata_i = {32'h0, 32'h99};
      cycle();
      chk("fwd_r0", ex_reg1_o, 32'h0);
      // load-use on r7 for three cycles
      reg1_addr_i = 7; fwd_wd_i = {5'd0, 5'd7}; fwd_wdata_i = {32'h0, 32'h77}; fwd_pending_i = 2'b01;
      repeat (3) begin
         cycle();
         chk("lu_bubble", ex_valid_o, 0);
         chk("lu_hazard", hazard_o, 1);
         chk("lu_ready", id_ready_o, 0);
      end
      chk("lu_cnt", stall_cnt_o, 3);
      fwd_pending_i = 0;
      cycle();
      chk("lu_accept", ex_reg1_o, 32'h77);
      chk("lu_cnt_hold", stall_cnt_o, 3);
      // backpressure then back-to-back
      fwd_wreg_i = 0; reg1_addr_i = 3; reg1_data_i = 32'hAB; ex_ready_i = 0;
      repeat (2) begin
         cycle();
         chk("bp_hold", ex_reg1_o, 32'h77);
         chk("bp_ready", id_ready_o, 0);
         chk("bp_cnt", stall_cnt_o, 3);
      end
      ex_ready_i = 1;
      cycle();
      chk("bp_next", ex_reg1_o, 32'hAB);
      reg1_data_i = 32'hCD;
      cycle();
      chk("bp_b2b", ex_reg1_o, 32'hCD);
      // flush during a hazard stall, then during a held slot
      reg1_addr_i = 7; fwd_wreg_i = 2'b01; fwd_pending_i = 2'b01;
      cycle();
      chk("fl_cnt_in", stall_cnt_o, 4);
      flush_i = 1;
      cycle();
      chk("fl_hz_valid", ex_valid_o, 0);
      chk("fl_hz_cnt", stall_cnt_o, 4);
      flush_i = 0; fwd_wreg_i = 0;
      cycle();
      ex_ready_i = 0; flush_i = 1;
      cycle();
      chk("fl_hold_valid", ex_valid_o, 0);
      chk("fl_hold_wreg", ex_wreg_o, 0);
      // async reset while holding a valid slot in STALL
      flush_i = 0; ex_ready_i = 1;
      cycle();
      ex_ready_i = 0; fwd_wreg_i = 2'b01;
      cycle();
      chk("ar_pre_valid", ex_valid_o, 1);
      chk("ar_pre_cnt", stall_cnt_o, 5);
      #2 rst = 0;
      #1;
      model_reset();
      chk("ar_valid", ex_valid_o, 0);
      chk("ar_wreg", ex_wreg_o, 0);
      chk("ar_reg1", ex_reg1_o, 0);
      chk("ar_cnt", stall_cnt_o, 0);
      @(posedge clk);
      #1 rst = 1;
      idle();
      // random traffic
      repeat (3000) begin
         id_valid_i = ($urandom_range(0, 4) != 0);
         reg1_read_i = $urandom_range(0, 3) != 0;
         reg2_read_i = $urandom_range(0, 3) != 0;
         reg1_addr_i = AW'($urandom_range(0, 3));
         reg2_addr_i = AW'($urandom_range(0, 3));
         reg1_data_i = $urandom; reg2_data_i = $urandom; imm_i = $urandom;
         aluop_i = OW'($urandom); alusel_i = SW'($urandom); wd_i = AW'($urandom); wreg_i = 1'($urandom);
         fwd_wreg_i = NF'($urandom);
         fwd_wd_i = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
         fwd_wdata_i = {$urandom, $urandom};
         fwd_pending_i = {1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0)};
         flush_i = ($urandom_range(0, 9) == 0);
         ex_ready_i = ($urandom_range(0, 3) != 0);
         cycle();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
